// File: rtl/fifo_nibble_tx.sv
// Drain stage for the 4-deep nibble FIFO: pops one word at a time and sends it
// as start, 4 data bits LSB first, optional even parity and stop on a one-wire line.
module fifo_nibble_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic [3:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shreg;
    logic          parity;
    logic          bit_done;
    logic          fetch;

    assign bit_done = (cnt == LAST);
    assign fetch    = (state == IDLE) && en && !fifo_empty;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (fetch) state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && idx == 2'd3) state_nxt = PARITY_EN ? PARITY : STOP;
            PARITY:  if (bit_done) state_nxt = STOP;
            STOP:    if (bit_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx decodes straight from state so reset forces the line high without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PARITY:  tx = parity;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            fifo_read   <= 1'b0;
            frames_sent <= '0;
        end else begin
            fifo_read <= fetch;
            if (state == IDLE) begin
                cnt <= '0;
                if (fetch) begin
                    shreg  <= fifo_dout;
                    parity <= 1'b0;
                    idx    <= 2'd0;
                end
            end else if (bit_done) begin
                cnt <= '0;
                if (state == DATA) begin
                    parity <= parity ^ shreg[0];
                    shreg  <= {1'b0, shreg[3:1]};
                    idx    <= idx + 2'd1;
                end
                if (state == STOP) begin
                    frames_sent <= frames_sent + 8'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/fifo_nibble_tx.md
# fifo_nibble_tx

Downstream drain stage for the 4-deep, 4-bit FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one nibble with a single-cycle `read` strobe and transmits it on a one-wire serial line:
- start bit, then 4 data bits LSB first, then optional even parity, then stop bit;
- each bit lasts a programmable number of clocks.

It is the consumer of the FIFO's `dout`/`empty` pair and the only driver of the FIFO's `read` input.

## Interface
- `CLKS_PER_BIT`, default 4: clocks per serial bit, legal range 1..255.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between data and stop; 0 omits it.
- `clk` input 1: single clock, all state updates on rising edge.
- `clr_n` input 1: reset, asynchronous, active-low.
- `en` input 1: permits fetching a new word; does not abort a frame in progress.
- `fifo_dout` input 4: FIFO head word, valid whenever `fifo_empty`=0.
- `fifo_empty` input 1: FIFO empty flag, treated as synchronous to `clk`.
- `fifo_read` output 1: registered pop strobe, high exactly one clock per fetched word.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from fetch through the last stop-bit cycle.
- `frames_sent` output 8: count of completed frames, wraps 255->0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Registers:
  - bit-period counter, width clog2(CLKS_PER_BIT)+1;
  - data bit index, 0..3;
  - 4-bit shift register;
  - parity accumulator.
- IDLE:
  - `tx`=1, `busy`=0.
  - At a clock edge with `en`=1 and `fifo_empty`=0, the block does all of the following on the same edge:
    - loads the shift register from `fifo_dout`;
    - sets `fifo_read`=1;
    - clears the period counter and parity;
    - enters START.
- START: `tx`=0 for CLKS_PER_BIT clocks, then DATA with index 0.
- DATA:
  - `tx`=shreg[0] for CLKS_PER_BIT clocks.
  - At the end of each bit: XOR that bit into parity, shift right, increment index.
  - After index 3: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: `tx`=XOR of the 4 data bits (even parity) for CLKS_PER_BIT clocks, then STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT clocks.
  - On the last stop cycle's closing edge: increment `frames_sent`, return to IDLE.
- `fifo_read` is high only in the first START clock. It is never asserted while `fifo_empty`=1 and never asserted twice per frame.
- `en` falling mid-frame: the current frame completes normally; no further fetch.
- `en` rising while empty: stay in IDLE with no strobe.
- Reset (`clr_n`=0, any time, including mid-frame):
  - immediately forces IDLE;
  - `tx`=1, `busy`=0, `fifo_read`=0, `frames_sent`=0;
  - clears counters and shift register;
  - any partially sent word is discarded.
- Unsupported: CLKS_PER_BIT=0.

## Timing
- Fetch latency: `fifo_read` and `tx`=0 appear in the clock after the qualifying edge in IDLE.
- Frame length: (6+PARITY_EN)*CLKS_PER_BIT clocks, counted from the first `tx`=0 clock through the last stop clock.
- Back-to-back frames:
  - IDLE always lasts at least one clock, so consecutive frames have at least 1 idle-high clock between the stop bit and the next start bit.
  - That IDLE clock gives the FIFO one clock to ripple its next word forward before `fifo_empty` is resampled.
- `busy` is high on exactly the clocks the state is not IDLE.
- `frames_sent` updates on the same edge that enters IDLE.

## Test plan
- Reset value check:
  - Stimulus: assert `clr_n`=0, release, leave `en`=0.
  - Required: `tx`=1, `busy`=0, `fifo_read`=0, `frames_sent`=0, held indefinitely.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=0:
  - Stimulus: FIFO holds 0xA, `en`=1.
  - Required:
    - one `fifo_read` pulse;
    - `tx` = 0,0,1,0,1,1, each held 4 clocks (24 clocks total);
    - `frames_sent`=1.
- Parity frame, PARITY_EN=1:
  - 0xA -> parity bit 0, frame 28 clocks.
  - 0x7 -> `tx` = 0,1,1,1,0,1,1 (parity bit 1).
- FIFO full, 4 words 0x1,0x2,0x3,0x4:
  - Required: exactly 4 `fifo_read` pulses, frames in order, one idle-high clock between frames.
  - Required: `frames_sent`=4, then no further strobe once `fifo_empty`=1.
- `en` dropped mid-frame (during DATA bit 1):
  - Required: the frame completes, `busy` falls after the stop bit, no further fetch while words remain.
- Reset mid-frame (`clr_n` low during DATA bit 2):
  - Required: `tx`=1 and `busy`=0 asynchronously, `frames_sent`=0.
  - Required: after release with `en`=1, the next frame starts with a fresh `fifo_read` of the next word.
